// File: rtl/rr_lock_arbiter_pkg.sv
// Shared types and constants for the locking round-robin arbiter.
package rr_arb_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    localparam int HOLD_W = 8;

endpackage

// File: rtl/rr_lock_arbiter_if.sv
// Request/grant bundle between the requesting engines and the arbiter.
// release_pulse carries the resource's "transaction finished" pulse (release is a reserved word).
interface rr_lock_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic           release_pulse;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           timeout;

    modport master (
        output req, release_pulse,
        input  grant, grant_id, busy, timeout
    );

    modport slave (
        input  req, release_pulse,
        output grant, grant_id, busy, timeout
    );
endinterface

// File: rtl/rr_lock_arbiter_picker.sv
// Combinational round-robin pick: rotate req by ptr, take the lowest set bit,
// then map the offset back to a requester index modulo N.
module rr_priority_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] winner
);
    localparam int IDW = $clog2(N);
    localparam logic [IDW:0] NV = (IDW+1)'(N);

    logic [N-1:0]   rot;
    logic [IDW-1:0] off;
    logic [IDW:0]   sum;

    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [IDW:0]   idx;
        logic [IDW-1:0] idx_w;
        always_comb begin
            idx = (IDW+1)'(gi) + {1'b0, ptr};
            if (idx >= NV) begin
                idx = idx - NV;
            end
            idx_w   = idx[IDW-1:0];
            rot[gi] = req[idx_w];
        end
    end

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDW'(i);
            end
        end
    end

    always_comb begin
        found = |rot;
        sum   = {1'b0, off} + {1'b0, ptr};
        if (sum >= NV) begin
            sum = sum - NV;
        end
        winner = sum[IDW-1:0];
    end
endmodule

// File: rtl/rr_lock_arbiter.sv
// N-way round-robin arbiter with transaction locking: a grant is held until release.
// Optional forced release after MAX_HOLD cycles when RR_LOCK_ARBITER_TIMEOUT_EN is defined.
module rr_lock_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input logic              clk,
    input logic              rst,
    rr_lock_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("rr_lock_arbiter: N must be in 2..16");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > (1 << HOLD_W) - 1) begin : g_bad_hold
        $error("rr_lock_arbiter: MAX_HOLD out of range");
    end

    state_t         state_reg, state_next;
    logic [N-1:0]   grant_reg, grant_next;
    logic [IDW-1:0] id_reg, id_next;
    logic [IDW-1:0] ptr_reg, ptr_next;
    logic           found;
    logic [IDW-1:0] winner;
    logic           hold_expired;
    logic           timeout_next;
    logic           load;

    rr_priority_picker #(.N(N)) u_picker (
        .req    (bus.req),
        .ptr    (ptr_reg),
        .found  (found),
        .winner (winner)
    );

`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_reg;
    logic              timeout_reg;

    assign hold_expired = (state_reg == GRANT) && (hold_reg == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= timeout_next;
            if (load) begin
                hold_reg <= '0;
            end else if (state_reg == GRANT) begin
                hold_reg <= hold_reg + 1'b1;
            end
        end
    end

    assign bus.timeout = timeout_reg;
`else
    assign hold_expired = 1'b0;
    assign bus.timeout  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            id_reg    <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            id_reg    <= id_next;
            ptr_reg   <= ptr_next;
        end
    end

    // IDLE arbitrates every cycle; GRANT only when the owner lets go.
    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        id_next      = id_reg;
        ptr_next     = ptr_reg;
        timeout_next = 1'b0;
        load         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    load = 1'b1;
                end
            end
            GRANT: begin
                if (bus.release_pulse || hold_expired) begin
                    timeout_next = hold_expired;
                    if (found) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                        grant_next = '0;
                        id_next    = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (load) begin
            state_next = GRANT;
            grant_next = N'(1) << winner;
            id_next    = winner;
            ptr_next   = (winner == IDW'(N - 1)) ? '0 : winner + IDW'(1);
        end
    end

    assign bus.grant    = grant_reg;
    assign bus.grant_id = id_reg;
    assign bus.busy     = |grant_reg;
endmodule
